xrbus_tx_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares the single XR-BUS transmit path among NUM_REQ source modules.
- Grants one requester at a time and latches its header and payload fields onto the bus source inputs.
- Issues a one-cycle tx_request, then waits for the bus rx_valid completion or a timeout.
- Reports per-requester done/err and feeds the fabric side of the XR-BUS top-level.

---
 rtl/xrbus_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_xrbus_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrbus_tx_arbiter.sv
// rtl/xrbus_tx_arbiter.sv - round-robin XR-BUS transmit arbiter and transaction sequencer
// Grants one requester at a time, launches its latched fields, then waits for completion or timeout.
module xrbus_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PTR_W          = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*16-1:0]   req_module_id,
  input  logic [NUM_REQ*16-1:0]   req_boundary_id,
  input  logic [NUM_REQ*8-1:0]    req_op_code,
  input  logic [NUM_REQ*1024-1:0] req_payload,
  input  logic [NUM_REQ*10-1:0]   req_payload_len,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic                    tx_request,
  output logic [15:0]             src_module_id,
  output logic [15:0]             src_boundary_id,
  output logic [7:0]              op_code,
  output logic [1023:0]           payload,
  output logic [9:0]              payload_len,
  input  logic                    bus_rx_valid,
  input  logic                    bus_integrity_ok,
  input  logic                    bus_timing_aligned,
  output logic                    busy,
  output logic [PTR_W-1:0]        cur_owner,
  output logic [15:0]             timeout_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [15:0]      timeout_count_q, timeout_count_d;
  logic [15:0]      src_module_id_q, src_module_id_d;
  logic [15:0]      src_boundary_id_q, src_boundary_id_d;
  logic [7:0]       op_code_q, op_code_d;
  logic [1023:0]    payload_q, payload_d;
  logic [9:0]       payload_len_q, payload_len_d;

  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W:0]   cand_sum;
  logic [PTR_W-1:0] cand_idx;
  logic [NUM_REQ-1:0] owner_onehot;

  // Rotating priority: scan req starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      cand_idx = cand_sum[PTR_W-1:0];
      if (!sel_found && req[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    owner_d           = owner_q;
    wait_cnt_d        = wait_cnt_q;
    err_d             = err_q;
    timeout_count_d   = timeout_count_q;
    src_module_id_d   = src_module_id_q;
    src_boundary_id_d = src_boundary_id_q;
    op_code_d         = op_code_q;
    payload_d         = payload_q;
    payload_len_d     = payload_len_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found && bus_timing_aligned) begin
          owner_d           = sel_idx;
          src_module_id_d   = req_module_id[16*sel_idx +: 16];
          src_boundary_id_d = req_boundary_id[16*sel_idx +: 16];
          op_code_d         = req_op_code[8*sel_idx +: 8];
          payload_d         = req_payload[1024*sel_idx +: 1024];
          payload_len_d     = req_payload_len[10*sel_idx +: 10];
          state_d           = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last wait cycle beats the timeout.
        if (bus_rx_valid) begin
          err_d   = ~bus_integrity_ok;
          state_d = S_DONE;
        end else if (wait_cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          if (timeout_count_q != 16'hFFFF) begin
            timeout_count_d = timeout_count_q + 16'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      rr_ptr_q          <= '0;
      owner_q           <= '0;
      wait_cnt_q        <= '0;
      err_q             <= 1'b0;
      timeout_count_q   <= '0;
      src_module_id_q   <= '0;
      src_boundary_id_q <= '0;
      op_code_q         <= '0;
      payload_q         <= '0;
      payload_len_q     <= '0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      owner_q           <= owner_d;
      wait_cnt_q        <= wait_cnt_d;
      err_q             <= err_d;
      timeout_count_q   <= timeout_count_d;
      src_module_id_q   <= src_module_id_d;
      src_boundary_id_q <= src_boundary_id_d;
      op_code_q         <= op_code_d;
      payload_q         <= payload_d;
      payload_len_q     <= payload_len_d;
    end
  end

  assign owner_onehot    = NUM_REQ'(1) << owner_q;
  assign grant           = (state_q == S_LAUNCH) ? owner_onehot : '0;
  assign tx_request      = (state_q == S_LAUNCH);
  assign done            = (state_q == S_DONE) ? owner_onehot : '0;
  assign err             = (state_q == S_DONE && err_q) ? owner_onehot : '0;
  assign busy            = (state_q != S_IDLE);
  assign cur_owner       = owner_q;
  assign timeout_count   = timeout_count_q;
  assign src_module_id   = src_module_id_q;
  assign src_boundary_id = src_boundary_id_q;
  assign op_code         = op_code_q;
  assign payload         = payload_q;
  assign payload_len     = payload_len_q;

endmodule

// File: tb/tb_xrbus_tx_arbiter.sv
// tb/tb_xrbus_tx_arbiter.sv - self-checking bench for xrbus_tx_arbiter
// Transaction-level model predicts owner, completion cycle, err and timeout count.
module tb_xrbus_tx_arbiter;

  localparam int N = 4;
  localparam int T = 8;
  localparam int P = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*16-1:0]   req_module_id;
  logic [N*16-1:0]   req_boundary_id;
  logic [N*8-1:0]    req_op_code;
  logic [N*1024-1:0] req_payload;
  logic [N*10-1:0]   req_payload_len;
  logic [N-1:0]      grant, done, err;
  logic              tx_request;
  logic [15:0]       src_module_id, src_boundary_id;
  logic [7:0]        op_code;
  logic [1023:0]     payload;
  logic [9:0]        payload_len;
  logic              bus_rx_valid, bus_integrity_ok, bus_timing_aligned;
  logic              busy;
  logic [P-1:0]      cur_owner;
  logic [15:0]       timeout_count;

  int checks = 0;
  int failures = 0;
  int model_rr = 0;
  int model_to = 0;
  int cyc = 0;

  logic [15:0]   e_mid, e_bid;
  logic [7:0]    e_op;
  logic [1023:0] e_pl;
  logic [9:0]    e_len;

  xrbus_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .PTR_W(P)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_module_id(req_module_id), .req_boundary_id(req_boundary_id),
    .req_op_code(req_op_code), .req_payload(req_payload), .req_payload_len(req_payload_len),
    .grant(grant), .done(done), .err(err), .tx_request(tx_request),
    .src_module_id(src_module_id), .src_boundary_id(src_boundary_id),
    .op_code(op_code), .payload(payload), .payload_len(payload_len),
    .bus_rx_valid(bus_rx_valid), .bus_integrity_ok(bus_integrity_ok),
    .bus_timing_aligned(bus_timing_aligned), .busy(busy),
    .cur_owner(cur_owner), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_fields();
    for (int i = 0; i < N; i++) begin
      req_module_id[16*i +: 16]  = 16'($urandom);
      req_boundary_id[16*i +: 16] = 16'($urandom);
      req_op_code[8*i +: 8]       = 8'($urandom);
      req_payload_len[10*i +: 10] = 10'($urandom);
      for (int w = 0; w < 32; w++) req_payload[1024*i + 32*w +: 32] = $urandom;
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return 0;
  endfunction

  // Full transaction: request, expect grant next cycle, respond after delay or let it time out.
  task automatic do_txn(input logic [N-1:0] r, input bit respond, input int delay, input bit ok);
    int own;
    int wait_len;
    bit exp_err;
    logic [N-1:0] oh;
    logic [P-1:0] own_p;
    own = model_pick(r);
    own_p = P'(own);
    oh = '0;
    oh[own] = 1'b1;
    scramble_fields();
    e_mid = req_module_id[16*own +: 16];
    e_bid = req_boundary_id[16*own +: 16];
    e_op  = req_op_code[8*own +: 8];
    e_pl  = req_payload[1024*own +: 1024];
    e_len = req_payload_len[10*own +: 10];
    req = r;
    bus_timing_aligned = 1'b1;
    step();
    checks++;
    if (grant !== oh || tx_request !== 1'b1)
      begin failures++; $display("FAIL launch_grant: got grant=%b tx=%b exp grant=%b tx=1", grant, tx_request, oh); end
    checks++;
    if (cur_owner !== own_p)
      begin failures++; $display("FAIL cur_owner: got %0d exp %0d", cur_owner, own); end
    checks++;
    if ({src_module_id, src_boundary_id, op_code, payload_len} !== {e_mid, e_bid, e_op, e_len} || payload !== e_pl)
      begin failures++; $display("FAIL launch_fields: got %h/%h/%h/%h pl=%h exp %h/%h/%h/%h pl=%h",
        src_module_id, src_boundary_id, op_code, payload_len, payload[63:0], e_mid, e_bid, e_op, e_len, e_pl[63:0]); end
    req = '0;
    scramble_fields();
    wait_len = respond ? delay + 1 : T;
    for (int c = 0; c < wait_len; c++) begin
      step();
      checks++;
      if (done !== '0 || grant !== '0 || tx_request !== 1'b0 || busy !== 1'b1)
        begin failures++; $display("FAIL wait_outputs: got done=%b grant=%b tx=%b busy=%b exp 0/0/0/1 at wait %0d",
          done, grant, tx_request, busy, c); end
      bus_rx_valid = respond && (c == delay);
      bus_integrity_ok = ok;
    end
    step();
    bus_rx_valid = 1'b0;
    exp_err = respond ? !ok : 1'b1;
    if (!respond && model_to < 65535) model_to++;
    model_rr = (own + 1) % N;
    checks++;
    if (done !== oh)
      begin failures++; $display("FAIL done: got %b exp %b", done, oh); end
    checks++;
    if (err !== (exp_err ? oh : {N{1'b0}}))
      begin failures++; $display("FAIL err: got %b exp %b", err, exp_err ? oh : {N{1'b0}}); end
    checks++;
    if (timeout_count !== 16'(model_to))
      begin failures++; $display("FAIL timeout_count: got %0d exp %0d", timeout_count, model_to); end
    checks++;
    if ({src_module_id, src_boundary_id, op_code, payload_len} !== {e_mid, e_bid, e_op, e_len} || payload !== e_pl)
      begin failures++; $display("FAIL fields_hold: got %h/%h/%h/%h exp %h/%h/%h/%h",
        src_module_id, src_boundary_id, op_code, payload_len, e_mid, e_bid, e_op, e_len); end
    step();
    checks++;
    if (busy !== 1'b0 || done !== '0 || err !== '0)
      begin failures++; $display("FAIL back_idle: got busy=%b done=%b err=%b exp 0/0/0", busy, done, err); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    bus_rx_valid = 1'b0;
    bus_integrity_ok = 1'b0;
    bus_timing_aligned = 1'b0;
    scramble_fields();
    step();
    step();
    checks++;
    if (grant !== '0 || done !== '0 || err !== '0 || tx_request !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL reset_ctrl: got grant=%b done=%b err=%b tx=%b busy=%b exp all 0",
        grant, done, err, tx_request, busy); end
    checks++;
    if (cur_owner !== '0 || timeout_count !== 16'd0)
      begin failures++; $display("FAIL reset_regs: got owner=%0d tcount=%0d exp 0/0", cur_owner, timeout_count); end
    checks++;
    if ({src_module_id, src_boundary_id, op_code, payload_len} !== '0 || payload !== '0)
      begin failures++; $display("FAIL reset_fields: got %h/%h/%h/%h exp 0", src_module_id, src_boundary_id, op_code, payload_len); end
    rst_n = 1'b1;
    model_rr = 0;
    model_to = 0;
  endtask

  task automatic test_contention();
    int last_g;
    int exp;
    int waited;
    logic [N-1:0] oh;
    req = {N{1'b1}};
    bus_timing_aligned = 1'b1;
    last_g = 0;
    for (int n = 0; n < 2 * N; n++) begin
      waited = 0;
      while (grant === '0 && waited < 10) begin step(); waited++; end
      checks++;
      if (waited >= 10)
        begin failures++; $display("FAIL contention_wait: got no grant in %0d cycles exp grant", waited); end
      exp = model_pick({N{1'b1}});
      oh = '0;
      oh[exp] = 1'b1;
      checks++;
      if (grant !== oh)
        begin failures++; $display("FAIL contention_order: got %b exp %b", grant, oh); end
      if (n > 0) begin
        checks++;
        if (cyc - last_g != 4)
          begin failures++; $display("FAIL contention_gap: got %0d exp 4", cyc - last_g); end
      end
      last_g = cyc;
      step();
      bus_rx_valid = 1'b1;
      bus_integrity_ok = 1'b1;
      step();
      bus_rx_valid = 1'b0;
      checks++;
      if (done !== oh || err !== '0)
        begin failures++; $display("FAIL contention_done: got done=%b err=%b exp %b/0", done, err, oh); end
      model_rr = (exp + 1) % N;
      if (n == 2 * N - 1) req = '0;
      step();
    end
    req = '0;
    step();
  endtask

  task automatic test_single();
    do_txn(4'b0100, 1'b1, 3, 1'b1);
  endtask

  task automatic test_timeout();
    do_txn(4'b0001, 1'b0, 0, 1'b1);
    do_txn(4'b0011, 1'b0, 0, 1'b0);
    do_txn(4'b1000, 1'b0, 0, 1'b1);
  endtask

  task automatic test_integrity();
    do_txn(4'b0100, 1'b1, 2, 1'b0);
    do_txn(4'b0001, 1'b1, T - 1, 1'b1);
    do_txn(4'b0010, 1'b1, T - 1, 1'b0);
  endtask

  task automatic test_alignment();
    req = 4'b0001;
    bus_timing_aligned = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (grant !== '0 || busy !== 1'b0 || tx_request !== 1'b0)
        begin failures++; $display("FAIL align_gate: got grant=%b busy=%b exp 0/0", grant, busy); end
    end
    bus_timing_aligned = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0001 || tx_request !== 1'b1)
      begin failures++; $display("FAIL align_release: got grant=%b tx=%b exp 0001/1", grant, tx_request); end
    req = '0;
    step();
    bus_rx_valid = 1'b1;
    bus_integrity_ok = 1'b1;
    step();
    bus_rx_valid = 1'b0;
    checks++;
    if (done !== 4'b0001 || err !== '0)
      begin failures++; $display("FAIL align_done: got done=%b err=%b exp 0001/0", done, err); end
    model_rr = 1;
    step();
  endtask

  task automatic test_reset_mid_wait();
    do_txn(4'b0010, 1'b1, 0, 1'b1);
    scramble_fields();
    req = 4'b1000;
    bus_timing_aligned = 1'b1;
    step();
    req = '0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_rr = 0;
    model_to = 0;
    checks++;
    if (busy !== 1'b0 || grant !== '0 || done !== '0 || tx_request !== 1'b0 || cur_owner !== '0 || timeout_count !== 16'd0)
      begin failures++; $display("FAIL midwait_reset: got busy=%b grant=%b done=%b tx=%b owner=%0d tc=%0d exp all 0",
        busy, grant, done, tx_request, cur_owner, timeout_count); end
    checks++;
    if ({src_module_id, src_boundary_id, op_code, payload_len} !== '0 || payload !== '0)
      begin failures++; $display("FAIL midwait_fields: got %h/%h/%h/%h exp 0", src_module_id, src_boundary_id, op_code, payload_len); end
    bus_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (done !== '0 || busy !== 1'b0)
        begin failures++; $display("FAIL stale_rx: got done=%b busy=%b exp 0/0", done, busy); end
    end
    bus_rx_valid = 1'b0;
    do_txn(4'b1010, 1'b1, 1, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    for (int n = 0; n < 25; n++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) begin
        req = N'($urandom_range(1, (1 << N) - 1));
        bus_timing_aligned = 1'b0;
        step();
        req = '0;
        bus_timing_aligned = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || grant !== '0)
          begin failures++; $display("FAIL withdraw: got busy=%b grant=%b exp 0/0", busy, grant); end
      end
      do_txn(r, $urandom_range(0, 3) != 0, $urandom_range(0, T - 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_integrity();
    test_alignment();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
